// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
package mem_arb_pkg;

   localparam int unsigned DW             = 16;
   localparam int unsigned TIMEOUT_DEF    = 15;
   localparam int unsigned STARVE_MAX_DEF = 4;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_IF_BUSY = 2'd1,
      S_DM_BUSY = 2'd2,
      S_IF_DROP = 2'd3
   } arb_state_t;

endpackage

// File: rtl/arb_timer.sv
// Busy-cycle watchdog: counts cycles from a start pulse and flags expiry
// once TIMEOUT busy cycles have elapsed without a clear.
module arb_timer
   import mem_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic i_start,
   input  logic i_clear,
   output logic o_expired
);

   localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic          r_run;
   logic [CW-1:0] r_cnt;

   // Counter holds at the expiry value until the owner clears it.
   assign o_expired = r_run && (r_cnt == CW'(TIMEOUT - 1));

   // Run flag and busy-cycle count; first busy cycle reads zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_run <= 1'b0;
         r_cnt <= '0;
      end else if (i_clear) begin
         r_run <= 1'b0;
         r_cnt <= '0;
      end else if (i_start) begin
         r_run <= 1'b1;
         r_cnt <= '0;
      end else if (r_run && !o_expired) begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one memory port between instruction fetch and data
// accesses. Data normally wins; a starvation counter forces a fetch after
// STARVE_MAX data grants. One transaction in flight, with watchdog abort.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT    = TIMEOUT_DEF,
   parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          if_req,
   input  logic [DW-1:0] if_addr,
   output logic [DW-1:0] if_rdata,
   output logic          if_done,
   output logic          if_err,
   output logic          fetch_stall,
   input  logic          flush,
   input  logic          dm_req,
   input  logic          dm_wr,
   input  logic [DW-1:0] dm_addr,
   input  logic [DW-1:0] dm_wdata,
   output logic [DW-1:0] dm_rdata,
   output logic          dm_done,
   output logic          dm_err,
   output logic          data_stall,
   output logic          mem_en,
   output logic          mem_wr,
   output logic [DW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ready,
   input  logic          mem_err
);

   localparam int unsigned SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

   arb_state_t    r_state;
   logic [SW-1:0] r_starve;
   logic [DW-1:0] r_if_rdata;
   logic [DW-1:0] r_dm_rdata;
   logic          r_if_done;
   logic          r_if_err;
   logic          r_dm_done;
   logic          r_dm_err;
   logic          r_mem_en;
   logic          r_mem_wr;
   logic [DW-1:0] r_mem_addr;
   logic [DW-1:0] r_mem_wdata;

   logic w_starved;
   logic w_can_grant;
   logic w_grant_if;
   logic w_grant_dm;
   logic w_expired;
   logic w_finish;

   assign w_starved   = (r_starve == SW'(STARVE_MAX));
   // No grant while a done pulse is out: the requester is still dropping req.
   assign w_can_grant = (r_state == S_IDLE) && !r_if_done && !r_dm_done;
   assign w_grant_if  = w_can_grant && if_req && !flush && (!dm_req || w_starved);
   assign w_grant_dm  = w_can_grant && dm_req && !w_grant_if;
   assign w_finish    = (r_state != S_IDLE) && (mem_ready || w_expired);

   arb_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk       (clk),
      .rst       (rst),
      .i_start   (w_grant_if | w_grant_dm),
      .i_clear   (w_finish),
      .o_expired (w_expired)
   );

   assign if_rdata    = r_if_rdata;
   assign if_done     = r_if_done;
   assign if_err      = r_if_err;
   assign dm_rdata    = r_dm_rdata;
   assign dm_done     = r_dm_done;
   assign dm_err      = r_dm_err;
   assign mem_en      = r_mem_en;
   assign mem_wr      = r_mem_wr;
   assign mem_addr    = r_mem_addr;
   assign mem_wdata   = r_mem_wdata;
   assign fetch_stall = rst & if_req & ~r_if_done;
   assign data_stall  = rst & dm_req & ~r_dm_done;

   // Arbitration FSM with registered command, result and pulse outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_starve    <= '0;
         r_if_rdata  <= '0;
         r_dm_rdata  <= '0;
         r_if_done   <= 1'b0;
         r_if_err    <= 1'b0;
         r_dm_done   <= 1'b0;
         r_dm_err    <= 1'b0;
         r_mem_en    <= 1'b0;
         r_mem_wr    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else begin
         r_mem_en  <= 1'b0;
         r_if_done <= 1'b0;
         r_if_err  <= 1'b0;
         r_dm_done <= 1'b0;
         r_dm_err  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_grant_if) begin
                  r_state     <= S_IF_BUSY;
                  r_mem_en    <= 1'b1;
                  r_mem_wr    <= 1'b0;
                  r_mem_addr  <= if_addr;
                  r_mem_wdata <= '0;
                  r_starve    <= '0;
               end else if (w_grant_dm) begin
                  r_state     <= S_DM_BUSY;
                  r_mem_en    <= 1'b1;
                  r_mem_wr    <= dm_wr;
                  r_mem_addr  <= dm_addr;
                  r_mem_wdata <= dm_wdata;
                  if (if_req && !w_starved) begin
                     r_starve <= r_starve + SW'(1);
                  end
               end
            end
            S_IF_BUSY: begin
               // A flush coinciding with completion discards the result directly.
               if (flush) begin
                  r_state <= w_finish ? S_IDLE : S_IF_DROP;
               end else if (mem_ready) begin
                  r_state    <= S_IDLE;
                  r_if_done  <= 1'b1;
                  r_if_err   <= mem_err;
                  r_if_rdata <= mem_rdata;
               end else if (w_expired) begin
                  r_state   <= S_IDLE;
                  r_if_done <= 1'b1;
                  r_if_err  <= 1'b1;
               end
            end
            S_DM_BUSY: begin
               if (mem_ready) begin
                  r_state   <= S_IDLE;
                  r_dm_done <= 1'b1;
                  r_dm_err  <= mem_err;
                  if (!r_mem_wr) begin
                     r_dm_rdata <= mem_rdata;
                  end
               end else if (w_expired) begin
                  r_state   <= S_IDLE;
                  r_dm_done <= 1'b1;
                  r_dm_err  <= 1'b1;
               end
            end
            S_IF_DROP: begin
               if (w_finish) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a transaction-level reference model
// checked every cycle, plus hand-computed cycle/value expectations.
module tb_mem_arbiter;

   localparam int TIMEOUT    = 15;
   localparam int STARVE_MAX = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req = 1'b0;
   logic [15:0] if_addr = '0;
   logic [15:0] if_rdata;
   logic        if_done, if_err, fetch_stall;
   logic        flush = 1'b0;
   logic        dm_req = 1'b0;
   logic        dm_wr = 1'b0;
   logic [15:0] dm_addr = '0;
   logic [15:0] dm_wdata = '0;
   logic [15:0] dm_rdata;
   logic        dm_done, dm_err, data_stall;
   logic        mem_en, mem_wr;
   logic [15:0] mem_addr, mem_wdata;
   logic [15:0] mem_rdata;
   logic        mem_ready, mem_err;

   mem_arbiter #(
      .TIMEOUT    (TIMEOUT),
      .STARVE_MAX (STARVE_MAX)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .if_req      (if_req),
      .if_addr     (if_addr),
      .if_rdata    (if_rdata),
      .if_done     (if_done),
      .if_err      (if_err),
      .fetch_stall (fetch_stall),
      .flush       (flush),
      .dm_req      (dm_req),
      .dm_wr       (dm_wr),
      .dm_addr     (dm_addr),
      .dm_wdata    (dm_wdata),
      .dm_rdata    (dm_rdata),
      .dm_done     (dm_done),
      .dm_err      (dm_err),
      .data_stall  (data_stall),
      .mem_en      (mem_en),
      .mem_wr      (mem_wr),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .mem_ready   (mem_ready),
      .mem_err     (mem_err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s (cycle %0d): got %0h want %0h", nm, cyc, act, exp);
      end
   endtask

   // ---------------- memory responder ----------------
   int resp_delay = 0;   // cycles after mem_en; -1 = never
   bit resp_err   = 1'b0;
   bit stray      = 1'b0;
   int wait_cnt   = -1;

   initial begin
      mem_ready = 1'b0;
      mem_err   = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk); #1;
         mem_ready = 1'b0;
         mem_err   = 1'b0;
         mem_rdata = 16'hDEAD;
         if (!rst) wait_cnt = -1;
         else if (mem_en) wait_cnt = resp_delay;
         if (wait_cnt == 0) begin
            mem_ready = 1'b1;
            mem_err   = resp_err;
            mem_rdata = mem_addr ^ 16'hA5A5;
            wait_cnt  = -1;
         end else if (wait_cnt > 0) begin
            wait_cnt--;
         end
         if (stray) begin
            mem_ready = 1'b1;
            mem_rdata = 16'h5555;
         end
      end
   end

   // ---------------- reference model ----------------
   int          m_owner  = 0;   // 0 none, 1 fetch, 2 data
   bit          m_drop   = 1'b0;
   int          m_cycles = 0;
   int          m_starve = 0;
   bit          e_mem_en = 0, e_mem_wr = 0;
   bit          e_if_done = 0, e_if_err = 0, e_dm_done = 0, e_dm_err = 0;
   logic [15:0] e_mem_addr = '0, e_mem_wdata = '0, e_if_rdata = '0, e_dm_rdata = '0;

   task automatic model_step();
      bit done_prev;
      bit fin;
      done_prev = e_if_done | e_dm_done;
      e_if_done = 0; e_if_err = 0; e_dm_done = 0; e_dm_err = 0; e_mem_en = 0;
      if (!rst) begin
         m_owner = 0; m_drop = 0; m_cycles = 0; m_starve = 0;
         e_mem_wr = 0; e_mem_addr = '0; e_mem_wdata = '0;
         e_if_rdata = '0; e_dm_rdata = '0;
         return;
      end
      if (m_owner == 0) begin
         if (!done_prev) begin
            if (if_req && !flush && (!dm_req || m_starve >= STARVE_MAX)) begin
               m_owner = 1; m_cycles = 1; m_starve = 0;
               e_mem_en = 1; e_mem_wr = 0; e_mem_addr = if_addr; e_mem_wdata = '0;
            end else if (dm_req) begin
               m_owner = 2; m_cycles = 1;
               if (if_req && m_starve < STARVE_MAX) m_starve++;
               e_mem_en = 1; e_mem_wr = dm_wr; e_mem_addr = dm_addr; e_mem_wdata = dm_wdata;
            end
         end
      end else begin
         if (m_owner == 1 && flush) m_drop = 1;
         fin = mem_ready || (m_cycles >= TIMEOUT);
         if (fin) begin
            if (!m_drop) begin
               if (m_owner == 1) begin
                  e_if_done = 1;
                  e_if_err  = mem_ready ? mem_err : 1'b1;
                  if (mem_ready) e_if_rdata = mem_rdata;
               end else begin
                  e_dm_done = 1;
                  e_dm_err  = mem_ready ? mem_err : 1'b1;
                  if (mem_ready && !e_mem_wr) e_dm_rdata = mem_rdata;
               end
            end
            m_owner = 0; m_drop = 0;
         end else begin
            m_cycles++;
         end
      end
   endtask

   // Per-cycle comparison against the model.
   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         model_step();
         #1;
         chk("mem_en",      mem_en,      e_mem_en);
         chk("mem_wr",      mem_wr,      e_mem_wr);
         chk("mem_addr",    mem_addr,    e_mem_addr);
         chk("mem_wdata",   mem_wdata,   e_mem_wdata);
         chk("if_done",     if_done,     e_if_done);
         chk("if_err",      if_err,      e_if_err);
         chk("if_rdata",    if_rdata,    e_if_rdata);
         chk("dm_done",     dm_done,     e_dm_done);
         chk("dm_err",      dm_err,      e_dm_err);
         chk("dm_rdata",    dm_rdata,    e_dm_rdata);
         chk("fetch_stall", fetch_stall, rst & if_req & ~e_if_done);
         chk("data_stall",  data_stall,  rst & dm_req & ~e_dm_done);
      end
   end

   function automatic logic sig(input int which);
      case (which)
         0:       return dm_done;
         1:       return if_done;
         default: return mem_en;
      endcase
   endfunction

   task automatic wait_for(input int which, input int limit, output int at);
      at = -1;
      for (int n = 0; n < limit; n++) begin
         @(posedge clk); #2;
         if (sig(which)) begin
            at = cyc;
            break;
         end
      end
   endtask

   // ---------------- directed tests ----------------
   int t0, at;
   int n_data, n_done, fetch_pos, en_at, en1, done_at;
   logic [15:0] en_addr;
   bit saw_if, saw_dm, drop_if, drop_dm;

   initial begin
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_mem_en",   mem_en,   0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_if_rdata", if_rdata, 0);
      chk("rst_dm_rdata", dm_rdata, 0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // Test 1: simultaneous fetch and data read, data first.
      resp_delay = 0;
      if_req = 1; if_addr = 16'h0040;
      dm_req = 1; dm_wr = 0; dm_addr = 16'h1000;
      t0 = cyc;
      wait_for(0, 10, at);
      chk("t1_dm_done_cycle", at - t0, 2);
      chk("t1_dm_rdata", dm_rdata, 16'hB5A5);
      @(negedge clk); dm_req = 0;
      wait_for(1, 10, at);
      chk("t1_if_done_cycle", at - t0, 5);
      chk("t1_if_rdata", if_rdata, 16'hA5E5);
      @(negedge clk); if_req = 0;
      repeat (2) @(negedge clk);

      // Test 2: data held high, fetch forced after the 4th data grant.
      if_req = 1; if_addr = 16'h0080;
      dm_req = 1; dm_wr = 0; dm_addr = 16'h3000;
      n_data = 0; n_done = 0; fetch_pos = -1;
      for (int n = 0; n < 80 && n_done < 6; n++) begin
         @(posedge clk); #2;
         drop_if = 0; drop_dm = 0;
         if (mem_en) begin
            if (mem_addr == 16'h0080) begin
               if (fetch_pos < 0) fetch_pos = n_data;
            end else begin
               n_data++;
            end
         end
         if (if_done) drop_if = 1;
         if (dm_done) begin
            n_done++;
            if (n_done == 6) drop_dm = 1;
         end
         @(negedge clk);
         if (drop_if) if_req = 0;
         if (drop_dm) dm_req = 0;
      end
      chk("t2_fetch_after_n_data", fetch_pos, 4);
      chk("t2_data_grants", n_data, 6);
      chk("t2_data_dones", n_done, 6);
      repeat (2) @(negedge clk);

      // Test 3: flush during fetch, late ready discarded, data follows.
      resp_delay = 3;
      if_req = 1; if_addr = 16'h0100;
      t0 = cyc;
      saw_if = 0; en_at = -1; en1 = 0; done_at = -1; en_addr = '0;
      for (int n = 0; n < 12; n++) begin
         @(posedge clk); #2;
         if (if_done) saw_if = 1;
         if (mem_en && cyc - t0 == 1) en1 = 1;
         if (mem_en && en_at < 0 && cyc - t0 > 1) begin
            en_at = cyc - t0;
            en_addr = mem_addr;
         end
         if (dm_done && done_at < 0) done_at = cyc - t0;
         @(negedge clk);
         case (cyc - t0)
            1: flush = 1;
            2: begin flush = 0; if_req = 0; end
            4: begin dm_req = 1; dm_wr = 0; dm_addr = 16'h1234; resp_delay = 0; end
            default: ;
         endcase
         if (done_at >= 0) dm_req = 0;
      end
      chk("t3_fetch_mem_en", en1, 1);
      chk("t3_no_if_done", saw_if, 0);
      chk("t3_data_mem_en_cycle", en_at, 6);
      chk("t3_data_addr", en_addr, 16'h1234);
      chk("t3_dm_done_cycle", done_at, 7);
      repeat (2) @(negedge clk);

      // Test 4: data write never answered, watchdog abort.
      resp_delay = -1;
      dm_req = 1; dm_wr = 1; dm_addr = 16'h2002; dm_wdata = 16'hBEEF;
      t0 = cyc;
      wait_for(0, 30, at);
      chk("t4_timeout_cycle", at - t0, 16);
      chk("t4_dm_err", dm_err, 1);
      chk("t4_dm_rdata_kept", dm_rdata, 16'hB791);
      @(negedge clk); dm_req = 0; dm_wr = 0;
      repeat (2) @(negedge clk);

      // Test 5: reset mid data transaction, then a fresh fetch.
      dm_req = 1; dm_wr = 0; dm_addr = 16'h0400;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("t5_mem_en",     mem_en,     0);
      chk("t5_mem_addr",   mem_addr,   0);
      chk("t5_mem_wdata",  mem_wdata,  0);
      chk("t5_dm_rdata",   dm_rdata,   0);
      chk("t5_data_stall", data_stall, 0);
      dm_req = 0;
      saw_dm = 0;
      for (int n = 0; n < 2; n++) begin
         @(posedge clk); #2;
         if (dm_done) saw_dm = 1;
         @(negedge clk);
      end
      rst = 1'b1;
      resp_delay = 0;
      if_req = 1; if_addr = 16'h0500;
      t0 = cyc;
      wait_for(1, 10, at);
      chk("t5_no_dm_done", saw_dm, 0);
      chk("t5_if_done_cycle", at - t0, 2);
      chk("t5_if_rdata", if_rdata, 16'hA0A5);
      @(negedge clk); if_req = 0;
      repeat (2) @(negedge clk);

      // Test 6: fetch returns an error.
      resp_err = 1;
      if_req = 1; if_addr = 16'h0600;
      t0 = cyc;
      @(posedge clk); #2;
      chk("t6_stall_busy", fetch_stall, 1);
      wait_for(1, 10, at);
      chk("t6_if_done_cycle", at - t0, 2);
      chk("t6_if_err", if_err, 1);
      chk("t6_stall_released", fetch_stall, 0);
      chk("t6_if_rdata", if_rdata, 16'hA3A5);
      @(negedge clk); if_req = 0; resp_err = 0;
      repeat (2) @(negedge clk);

      // Test 7: flush in idle blocks the fetch; stray ready in idle ignored.
      stray = 1; flush = 1;
      if_req = 1; if_addr = 16'h0700;
      t0 = cyc;
      @(posedge clk); #2;
      chk("t7_blocked_mem_en", mem_en, 0);
      chk("t7_stray_no_done", if_done | dm_done, 0);
      @(negedge clk); stray = 0; flush = 0;
      wait_for(2, 10, at);
      chk("t7_mem_en_cycle", at - t0, 2);
      wait_for(1, 10, at);
      chk("t7_if_done_cycle", at - t0, 3);
      @(negedge clk); if_req = 0;
      repeat (3) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: max cycles waiting on mem_ready before abort.
REQ-002 SHALL have parameter STARVE_MAX, default 4: max consecutive data grants while a fetch waits.
REQ-003 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-low reset (rst=0 resets).
REQ-005 SHALL have ports if_req in 1, if_addr in 16: fetch request and PC, both held until if_done.
REQ-006 SHALL have ports if_rdata out 16, if_done out 1, if_err out 1: fetch result, one-cycle done pulse, error with done.
REQ-007 SHALL have port fetch_stall  out  1: to the IF/ID latch, equal to if_req & ~if_done.
REQ-008 SHALL have port flush  in  1: branch or exception cancels any pending or in-flight fetch.
REQ-009 SHALL have ports dm_req in 1, dm_wr in 1, dm_addr in 16, dm_wdata in 16: data request, held until dm_done.
REQ-010 SHALL have ports dm_rdata out 16, dm_done out 1, dm_err out 1, data_stall out 1 (dm_req & ~dm_done).
REQ-011 SHALL have ports mem_en out 1, mem_wr out 1, mem_addr out 16, mem_wdata out 16: shared memory command.
REQ-012 SHALL have ports mem_rdata in 16, mem_ready in 1, mem_err in 1: memory response, valid while mem_ready=1.

Function
REQ-013 SHALL implement states IDLE, IF_BUSY, DM_BUSY, IF_DROP.
REQ-014 In IDLE, dm_req SHALL win over if_req, except that if_req SHALL win once the starvation count equals STARVE_MAX.
REQ-015 Starvation count SHALL increment on each data grant made while if_req=1, clear on every fetch grant, and saturate at STARVE_MAX.
REQ-016 On a grant, the arbiter SHALL register the address, write data and write flag, and SHALL assert mem_en for exactly the first busy cycle.
REQ-017 mem_addr, mem_wdata and mem_wr SHALL hold stable for the whole busy state.
REQ-018 In a busy state, mem_ready=1 SHALL capture mem_rdata and mem_err and return to IDLE; done SHALL pulse the following cycle.
REQ-019 Minimum latency SHALL be: request at cycle 0, mem_en at cycle 1, mem_ready at cycle 1, done at cycle 2.
REQ-020 Data writes SHALL leave dm_rdata unchanged and SHALL pulse dm_done.
REQ-021 flush in IF_BUSY SHALL move the FSM to IF_DROP; IF_DROP SHALL wait for mem_ready, discard the result, and return to IDLE with no if_done.
REQ-022 flush in IDLE SHALL block a fetch grant that cycle; a data grant in the same cycle SHALL proceed.
REQ-023 A busy-cycle counter SHALL abort after TIMEOUT cycles without mem_ready: return to IDLE and pulse done plus err for the owner (no pulse in IF_DROP).
REQ-024 A mem_ready that arrives while in IDLE SHALL be ignored.
REQ-025 Only one memory transaction SHALL be in flight at any time; no new grant SHALL occur in the cycle a done is pulsed.

Reset
REQ-026 rst=0 SHALL asynchronously force IDLE, clear both counters, and set every output to 0, including the rdata outputs.
REQ-027 Reset during a busy state SHALL abandon the transaction with no done or err pulse.
REQ-028 The first grant after rst rises SHALL occur no earlier than the first clock edge with rst=1.

Structure
REQ-029 State encoding, the 16-bit width constant, and TIMEOUT/STARVE_MAX defaults SHALL live in shared package mem_arb_pkg.
REQ-030 The timeout counter SHALL be a separate sub-module arb_timer (start, clear, expired).

Verification
REQ-031 Test 1: simultaneous if_req(0x0040) and dm_req read (0x1000), mem_ready one cycle after mem_en -> data grant first, dm_done cycle 2, then fetch grant, if_done cycle 5.
REQ-032 Test 2: dm_req held high for 6 back-to-back transactions with if_req pending -> fetch granted after the 4th data grant.
REQ-033 Test 3: flush one cycle after fetch grant, mem_ready 3 cycles later -> no if_done, IDLE, next dm_req granted the following cycle.
REQ-034 Test 4: data write 0xBEEF to 0x2002 with mem_ready never asserted -> dm_done and dm_err pulse 15 busy cycles after grant, dm_rdata unchanged.
REQ-035 Test 5: rst=0 mid DM_BUSY -> all outputs 0 immediately, no dm_done, and a fresh if_req after release completes normally.
REQ-036 Test 6: mem_err=1 with mem_ready on a fetch -> if_err and if_done pulse together, fetch_stall deasserts that cycle.
